// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: core run/idle encoding
// and the loader FSM state encoding.
package imem_loader_pkg;

  localparam logic CORE_IDLE = 1'b0;
  localparam logic CORE_EXEC = 1'b1;

  typedef enum logic [2:0] {
    LD_IDLE    = 3'd0,
    LD_LOAD_HI = 3'd1,
    LD_LOAD_LO = 3'd2,
    LD_DONE    = 3'd3,
    LD_RUN     = 3'd4
  } ld_state_e;

  // The byte stream is open only while a word is being assembled.
  function automatic logic accepts_bytes(input ld_state_e s);
    return (s == LD_LOAD_HI) || (s == LD_LOAD_LO);
  endfunction

endpackage

// File: rtl/imem_loader_ram.sv
// Instruction RAM: one synchronous write port for the loader, one asynchronous
// read port for the fetch stage (old data is visible until the write edge).
module imem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; a program must survive a reset, and a
  // reset port on the array would also stop it mapping onto RAM cells.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a byte-serial program loader; holds the core in reset
// while a program loads and releases it once the load completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter bit AUTORUN = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_datain,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  output logic              state,
  output logic              cpu_rst_n
);

  ld_state_e         fsm;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        hi_byte;
  logic              wr_en;
  logic              last_word;

  assign ld_ready = accepts_bytes(fsm);

  // A start pulse wins over a coincident byte, so that byte never reaches memory.
  assign wr_en     = (fsm == LD_LOAD_LO) && ld_valid && !ld_start;
  assign last_word = ld_last || (wr_addr == {ADDR_W{1'b1}});

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (DATA_W'({hi_byte, ld_byte})),
    .raddr (i_addr),
    .rdata (i_datain)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm       <= AUTORUN ? LD_RUN : LD_IDLE;
      wr_addr   <= '0;
      ld_count  <= '0;
      hi_byte   <= '0;
      state     <= AUTORUN ? CORE_EXEC : CORE_IDLE;
      cpu_rst_n <= AUTORUN;
    end else if (ld_start && fsm != LD_DONE) begin
      fsm       <= LD_LOAD_HI;
      wr_addr   <= '0;
      ld_count  <= '0;
      state     <= CORE_IDLE;
      cpu_rst_n <= 1'b0;
    end else begin
      case (fsm)
        LD_LOAD_HI: begin
          if (ld_valid) begin
            hi_byte <= ld_byte;
            fsm     <= LD_LOAD_LO;
          end
        end
        LD_LOAD_LO: begin
          if (ld_valid) begin
            wr_addr  <= wr_addr + 1'b1;
            ld_count <= ld_count + 1'b1;
            fsm      <= last_word ? LD_DONE : LD_LOAD_HI;
          end
        end
        LD_DONE: begin
          // Outputs follow the state being entered, so the core sees RUN glitch-free.
          fsm       <= LD_RUN;
          state     <= CORE_EXEC;
          cpu_rst_n <= 1'b1;
        end
        LD_IDLE, LD_RUN: ;
        default: begin
          fsm       <= LD_IDLE;
          state     <= CORE_IDLE;
          cpu_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: a word-level memory model is
// updated from each word the bench sends and compared through the read port.
`timescale 1ns/1ps
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  i_addr = '0;
  logic [15:0] i_datain;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic [8:0]  ld_count;
  logic        state;
  logic        cpu_rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model_mem   [256];
  bit          model_known [256];
  int          exp_addr;
  int          exp_count;
  bit          gaps;

  imem_loader #(.ADDR_W(8), .DATA_W(16), .AUTORUN(1'b0)) dut (
    .clock     (clock),
    .reset     (reset),
    .i_addr    (i_addr),
    .i_datain  (i_datain),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_byte   (ld_byte),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_count  (ld_count),
    .state     (state),
    .cpu_rst_n (cpu_rst_n)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // The core must never see an open byte stream while it is running.
  always @(negedge clock) begin
    if (reset === 1'b1 && state === CORE_EXEC) check("ready_in_run", ld_ready, 0);
  end

  task automatic model_start();
    exp_addr  = 0;
    exp_count = 0;
  endtask

  task automatic pulse_start(input bit with_byte);
    ld_start = 1'b1;
    ld_valid = with_byte;
    ld_byte  = 8'h77;
    ld_last  = with_byte;
    @(negedge clock);
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    model_start();
    check("ready_after_start", ld_ready, 1);
    check("count_after_start", ld_count, 0);
  endtask

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int budget = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        ld_valid = 1'b0;
        ld_byte  = 8'($urandom);
        ld_last  = 1'($urandom);
        @(negedge clock);
      end
    end
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    while (ld_ready !== 1'b1 && budget < 20) begin
      @(negedge clock);
      budget++;
    end
    if (budget >= 20) check("ready_timeout", 0, 1);
    @(negedge clock);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic last, input logic hi_last);
    send_byte(w[15:8], hi_last);
    send_byte(w[7:0], last);
    model_mem[exp_addr]   = w;
    model_known[exp_addr] = 1'b1;
    exp_addr++;
    exp_count++;
  endtask

  // At the negedge after the final handshake the loader is in DONE; one edge later RUN.
  task automatic check_done_run(input string tag);
    check({tag, "_done_ready"}, ld_ready, 0);
    check({tag, "_done_state"}, state, CORE_IDLE);
    check({tag, "_done_rst"}, cpu_rst_n, 0);
    check({tag, "_count"}, ld_count, exp_count);
    @(negedge clock);
    check({tag, "_run_state"}, state, CORE_EXEC);
    check({tag, "_run_rst"}, cpu_rst_n, 1);
    check({tag, "_run_ready"}, ld_ready, 0);
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 256; a++) begin
      if (model_known[a]) begin
        i_addr = 8'(a);
        #1;
        check($sformatf("%s_mem[%0d]", tag, a), i_datain, model_mem[a]);
      end
    end
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int n;
    for (int a = 0; a < 256; a++) model_known[a] = 1'b0;
    gaps = 1'b0;
    model_start();

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_ready", ld_ready, 0);
    check("rst_state", state, CORE_IDLE);
    check("rst_cpu", cpu_rst_n, 0);
    check("rst_count", ld_count, 0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_ready", ld_ready, 0);

    // Test 1: three-word program
    pulse_start(1'b0);
    send_word(16'h1234, 1'b0, 1'b0);
    send_word(16'h5678, 1'b0, 1'b0);
    send_word(16'h9ABC, 1'b1, 1'b0);
    check_done_run("t1");
    i_addr = 8'd1;
    #1 check("t1_read1", i_datain, 16'h5678);
    @(negedge clock);
    check_mem("t1");

    // Test 2: same program with random valid gaps, then random programs
    for (int a = 0; a < 3; a++) model_known[a] = 1'b0;
    gaps = 1'b1;
    pulse_start(1'b0);
    send_word(16'h1234, 1'b0, 1'b0);
    send_word(16'h5678, 1'b0, 1'b0);
    send_word(16'h9ABC, 1'b1, 1'b0);
    check_done_run("t2");
    check_mem("t2");
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 12);
      pulse_start(1'b0);
      for (int k = 0; k < n; k++) begin
        w = 16'($urandom);
        send_word(w, k == n - 1, 1'($urandom));
      end
      check_done_run($sformatf("rand%0d", r));
      check_mem($sformatf("rand%0d", r));
    end

    // Test 3: restart after 1.5 words; start wins over a coincident byte
    pulse_start(1'b0);
    send_word(16'hABCD, 1'b0, 1'b0);
    send_byte(8'hEF, 1'b0);
    pulse_start(1'b1);
    send_word(16'h1122, 1'b1, 1'b0);
    check_done_run("t3");
    check_mem("t3");

    // Test 4: 256 words without ld_last end the load on their own
    gaps = 1'b0;
    pulse_start(1'b0);
    for (int k = 0; k < 256; k++) send_word(16'(k), 1'b0, 1'b0);
    check("t4_count256", ld_count, 256);
    check_done_run("t4");
    i_addr = 8'd255;
    #1 check("t4_read255", i_datain, 16'h00FF);
    @(negedge clock);
    check_mem("t4");

    // Test 5: reset while a low byte is pending
    gaps = 1'b1;
    pulse_start(1'b0);
    send_word(16'($urandom), 1'b0, 1'b0);
    send_word(16'($urandom), 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0);
    check("t5_ready_lo", ld_ready, 1);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_ready", ld_ready, 0);
    check("t5_rst_state", state, CORE_IDLE);
    check("t5_rst_cpu", cpu_rst_n, 0);
    check("t5_rst_count", ld_count, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t5_idle_ready", ld_ready, 0);
    check_mem("t5");

    // Test 6: ld_start while running restarts the load
    pulse_start(1'b0);
    send_word(16'($urandom), 1'b1, 1'b0);
    check_done_run("t6a");
    ld_start = 1'b1;
    @(negedge clock);
    ld_start = 1'b0;
    model_start();
    check("t6_state", state, CORE_IDLE);
    check("t6_cpu", cpu_rst_n, 0);
    check("t6_ready", ld_ready, 1);
    send_word(16'($urandom), 1'b1, 1'b0);
    check_done_run("t6b");
    check_mem("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
